// File: rtl/tartaruga_pkg.sv
// tartaruga_pkg: shared types and defaults for the tartaruga core reorder buffer.
package tartaruga_pkg;
  localparam int ROB_DEPTH  = 16;
  localparam int ROB_NUM_WB = 2;
  typedef struct packed {
    logic        valid;
    logic        completed;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic        store;
    logic [31:0] result;
    logic [31:0] new_pc;
    logic        branch_taken;
  } rob_mp_entry_t;
endpackage

// File: rtl/rob_mp_lookup.sv
// rob_mp_lookup: youngest pending producer search for one source register, with write-back bypass.
module rob_mp_lookup #(
  parameter int DEPTH  = 16,
  parameter int NUM_WB = 2,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]           cand_i,
  input  logic [DEPTH-1:0]           done_i,
  input  logic [DEPTH-1:0][4:0]      rd_i,
  input  logic [DEPTH-1:0][31:0]     res_i,
  input  logic [IDX_W-1:0]           head_i,
  input  logic [4:0]                 rs_i,
  input  logic [NUM_WB-1:0]          wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0]    wb_idx_i,
  input  logic [NUM_WB*32-1:0]       wb_result_i,
  output logic                       hazard_o,
  output logic [IDX_W-1:0]           idx_o,
  output logic                       completed_o,
  output logic [31:0]                result_o
);
  logic [IDX_W-1:0] w_idx;
  // Walk from head towards tail so the last hit is the youngest producer.
  always_comb begin
    hazard_o    = 1'b0;
    idx_o       = '0;
    completed_o = 1'b0;
    result_o    = '0;
    w_idx       = '0;
    for (int a = 0; a < DEPTH; a++) begin
      w_idx = head_i + IDX_W'(a);
      if (rs_i != 5'd0 && cand_i[w_idx] && rd_i[w_idx] == rs_i) begin
        hazard_o    = 1'b1;
        idx_o       = w_idx;
        completed_o = done_i[w_idx];
        result_o    = res_i[w_idx];
      end
    end
    for (int p = 0; p < NUM_WB; p++) begin
      if (hazard_o && wb_valid_i[p] && wb_idx_i[p*IDX_W +: IDX_W] == idx_o) begin
        completed_o = 1'b1;
        result_o    = wb_result_i[p*32 +: 32];
      end
    end
  end
endmodule

// File: rtl/rob_mp.sv
// rob_mp: reorder buffer, in-order allocate, out-of-order multi-port write-back, in-order commit.
module rob_mp
  import tartaruga_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int NUM_WB = ROB_NUM_WB,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_i,
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  input  logic [31:0]             pc_i,
  input  logic [31:0]             instr_i,
  input  logic [4:0]              rd_addr_i,
  input  logic                    write_enable_i,
  input  logic                    store_to_mem_i,
  output logic [IDX_W-1:0]        alloc_idx_o,
  input  logic [NUM_WB-1:0]       wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx_i,
  input  logic [NUM_WB*32-1:0]    wb_result_i,
  input  logic [NUM_WB*32-1:0]    wb_new_pc_i,
  input  logic [NUM_WB-1:0]       wb_branch_taken_i,
  output logic                    commit_valid_o,
  input  logic                    commit_ready_i,
  output logic [31:0]             commit_pc_o,
  output logic [31:0]             commit_instr_o,
  output logic [31:0]             commit_result_o,
  output logic [31:0]             commit_new_pc_o,
  output logic [4:0]              commit_rd_addr_o,
  output logic                    commit_write_enable_o,
  output logic                    commit_store_to_mem_o,
  output logic                    commit_branch_taken_o,
  output logic                    rob_full_o,
  output logic                    rob_empty_o,
  input  logic [4:0]              rs1_addr_i,
  input  logic [4:0]              rs2_addr_i,
  output logic                    hazard_rs1_o,
  output logic                    hazard_rs2_o,
  output logic [IDX_W-1:0]        rob_entry_rs1_o,
  output logic [IDX_W-1:0]        rob_entry_rs2_o,
  output logic                    completed_rs1_o,
  output logic                    completed_rs2_o,
  output logic [31:0]             result_rs1_o,
  output logic [31:0]             result_rs2_o
);
  rob_mp_entry_t [DEPTH-1:0] r_rob;
  logic [IDX_W-1:0]          r_head, r_tail;
  logic [IDX_W:0]            r_count;
  rob_mp_entry_t             w_hd;
  logic                      w_alloc, w_commit;
  logic [DEPTH-1:0]          w_cand, w_done;
  logic [DEPTH-1:0][4:0]     w_rd;
  logic [DEPTH-1:0][31:0]    w_res;
  assign alloc_ready_o  = r_count != (IDX_W+1)'(DEPTH);
  assign rob_full_o     = !alloc_ready_o;
  assign rob_empty_o    = r_count == '0;
  assign alloc_idx_o    = r_tail;
  assign w_hd           = r_rob[r_head];
  assign commit_valid_o = w_hd.valid & w_hd.completed & ~flush_i;
  assign w_alloc        = alloc_valid_i & alloc_ready_o & ~flush_i;
  assign w_commit       = commit_valid_o & commit_ready_i;
  assign commit_pc_o           = commit_valid_o ? w_hd.pc : '0;
  assign commit_instr_o        = commit_valid_o ? w_hd.instr : '0;
  assign commit_result_o       = commit_valid_o ? w_hd.result : '0;
  assign commit_new_pc_o       = commit_valid_o ? w_hd.new_pc : '0;
  assign commit_rd_addr_o      = commit_valid_o ? w_hd.rd : '0;
  assign commit_write_enable_o = commit_valid_o & w_hd.we;
  assign commit_store_to_mem_o = commit_valid_o & w_hd.store;
  assign commit_branch_taken_o = commit_valid_o & w_hd.branch_taken;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_cand[i] = r_rob[i].valid & r_rob[i].we;
      w_done[i] = r_rob[i].completed;
      w_rd[i]   = r_rob[i].rd;
      w_res[i]  = r_rob[i].result;
    end
  end
  // Write-backs test the pre-edge valid bit, so a slot allocated this cycle ignores them.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      r_rob   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_i[p] && r_rob[wb_idx_i[p*IDX_W +: IDX_W]].valid) begin
          r_rob[wb_idx_i[p*IDX_W +: IDX_W]].completed    <= 1'b1;
          r_rob[wb_idx_i[p*IDX_W +: IDX_W]].result       <= wb_result_i[p*32 +: 32];
          r_rob[wb_idx_i[p*IDX_W +: IDX_W]].new_pc       <= wb_new_pc_i[p*32 +: 32];
          r_rob[wb_idx_i[p*IDX_W +: IDX_W]].branch_taken <= wb_branch_taken_i[p];
        end
      end
      if (w_commit) r_rob[r_head].valid <= 1'b0;
      if (w_alloc) r_rob[r_tail] <= '{valid: 1'b1, completed: 1'b0, pc: pc_i, instr: instr_i,
                                     rd: rd_addr_i, we: write_enable_i, store: store_to_mem_i,
                                     result: '0, new_pc: '0, branch_taken: 1'b0};
      r_head  <= r_head + IDX_W'(w_commit);
      r_tail  <= r_tail + IDX_W'(w_alloc);
      r_count <= r_count + (IDX_W+1)'(w_alloc) - (IDX_W+1)'(w_commit);
    end
  end
  rob_mp_lookup #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .IDX_W(IDX_W)) u_rs1 (
    .cand_i(w_cand), .done_i(w_done), .rd_i(w_rd), .res_i(w_res), .head_i(r_head),
    .rs_i(rs1_addr_i), .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .hazard_o(hazard_rs1_o), .idx_o(rob_entry_rs1_o), .completed_o(completed_rs1_o),
    .result_o(result_rs1_o)
  );
  rob_mp_lookup #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .IDX_W(IDX_W)) u_rs2 (
    .cand_i(w_cand), .done_i(w_done), .rd_i(w_rd), .res_i(w_res), .head_i(r_head),
    .rs_i(rs2_addr_i), .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .hazard_o(hazard_rs2_o), .idx_o(rob_entry_rs2_o), .completed_o(completed_rs2_o),
    .result_o(result_rs2_o)
  );
endmodule

// File: tb/tb_rob_mp.sv
// tb_rob_mp: directed scenario bench for rob_mp with hand-computed expectations.
module tb_rob_mp;
  logic        clk_i = 1'b0;
  logic        rstn_i, flush_i, alloc_valid_i, alloc_ready_o;
  logic [31:0] pc_i, instr_i;
  logic [4:0]  rd_addr_i;
  logic        write_enable_i, store_to_mem_i;
  logic [3:0]  alloc_idx_o;
  logic [1:0]  wb_valid_i, wb_branch_taken_i;
  logic [7:0]  wb_idx_i;
  logic [63:0] wb_result_i, wb_new_pc_i;
  logic        commit_valid_o, commit_ready_i;
  logic [31:0] commit_pc_o, commit_instr_o, commit_result_o, commit_new_pc_o;
  logic [4:0]  commit_rd_addr_o;
  logic        commit_write_enable_o, commit_store_to_mem_o, commit_branch_taken_o;
  logic        rob_full_o, rob_empty_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic        hazard_rs1_o, hazard_rs2_o, completed_rs1_o, completed_rs2_o;
  logic [3:0]  rob_entry_rs1_o, rob_entry_rs2_o;
  logic [31:0] result_rs1_o, result_rs2_o;
  int total = 0;
  int bad = 0;

  rob_mp dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .alloc_valid_i(alloc_valid_i),
    .alloc_ready_o(alloc_ready_o), .pc_i(pc_i), .instr_i(instr_i), .rd_addr_i(rd_addr_i),
    .write_enable_i(write_enable_i), .store_to_mem_i(store_to_mem_i), .alloc_idx_o(alloc_idx_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .wb_new_pc_i(wb_new_pc_i), .wb_branch_taken_i(wb_branch_taken_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i), .commit_pc_o(commit_pc_o),
    .commit_instr_o(commit_instr_o), .commit_result_o(commit_result_o),
    .commit_new_pc_o(commit_new_pc_o), .commit_rd_addr_o(commit_rd_addr_o),
    .commit_write_enable_o(commit_write_enable_o), .commit_store_to_mem_o(commit_store_to_mem_o),
    .commit_branch_taken_o(commit_branch_taken_o), .rob_full_o(rob_full_o),
    .rob_empty_o(rob_empty_o), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .hazard_rs1_o(hazard_rs1_o), .hazard_rs2_o(hazard_rs2_o),
    .rob_entry_rs1_o(rob_entry_rs1_o), .rob_entry_rs2_o(rob_entry_rs2_o),
    .completed_rs1_o(completed_rs1_o), .completed_rs2_o(completed_rs2_o),
    .result_rs1_o(result_rs1_o), .result_rs2_o(result_rs2_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    flush_i = 0; alloc_valid_i = 0; pc_i = 0; instr_i = 0; rd_addr_i = 0;
    write_enable_i = 0; store_to_mem_i = 0; wb_valid_i = 0; wb_idx_i = 0;
    wb_result_i = 0; wb_new_pc_i = 0; wb_branch_taken_i = 0; commit_ready_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0;
  endtask

  task automatic do_reset();
    clr_in();
    rstn_i = 0;
    tick();
    rstn_i = 1;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic we);
    alloc_valid_i = 1; pc_i = pc; instr_i = pc ^ 32'h13; rd_addr_i = rd; write_enable_i = we;
  endtask

  task automatic set_wb(input int p, input logic [3:0] idx, input logic [31:0] res);
    wb_valid_i[p] = 1'b1;
    wb_idx_i[p*4 +: 4] = idx;
    wb_result_i[p*32 +: 32] = res;
    wb_new_pc_i[p*32 +: 32] = res + 32'd4;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_addr_i = 5'd1; rs2_addr_i = 5'd2;
    #1;
    total++; if (alloc_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", alloc_ready_o); end
    total++; if (rob_empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0h exp=1", rob_empty_o); end
    total++; if (rob_full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", rob_full_o); end
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL reset_cvalid got=%0h exp=0", commit_valid_o); end
    total++; if ({hazard_rs1_o, hazard_rs2_o} !== 2'b00) begin bad++; $display("FAIL reset_hazard got=%0b exp=00", {hazard_rs1_o, hazard_rs2_o}); end
    total++; if (alloc_idx_o !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", alloc_idx_o); end
  endtask

  task automatic test_basic();
    do_reset();
    set_alloc(32'h4, 5'd1, 1'b1);
    #1;
    total++; if (alloc_idx_o !== 4'd0) begin bad++; $display("FAIL basic_idx got=%0d exp=0", alloc_idx_o); end
    tick();
    clr_in();
    set_wb(0, 4'd0, 32'hDEADBEEF);
    commit_ready_i = 1;
    #1;
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early got=%0h exp=0", commit_valid_o); end
    tick();
    wb_valid_i = 0;
    #1;
    total++; if (commit_valid_o !== 1'b1) begin bad++; $display("FAIL basic_cvalid got=%0h exp=1", commit_valid_o); end
    total++; if (commit_result_o !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_result got=%h exp=deadbeef", commit_result_o); end
    total++; if (commit_pc_o !== 32'h4 || commit_rd_addr_o !== 5'd1 || commit_write_enable_o !== 1'b1) begin bad++; $display("FAIL basic_payload got=%h/%0d/%0h exp=4/1/1", commit_pc_o, commit_rd_addr_o, commit_write_enable_o); end
    tick();
    total++; if (rob_empty_o !== 1'b1 || commit_valid_o !== 1'b0) begin bad++; $display("FAIL basic_drained got=%0h/%0h exp=1/0", rob_empty_o, commit_valid_o); end
  endtask

  task automatic test_ooo();
    logic [31:0] exp_res [3];
    exp_res = '{32'h11, 32'hFEEDFACE, 32'hCAFEBABE};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(32'(i * 4), 5'(i + 1), 1'b1);
      tick();
    end
    clr_in();
    commit_ready_i = 1;
    set_wb(0, 4'd2, 32'hCAFEBABE);
    tick();
    wb_valid_i = 0;
    set_wb(0, 4'd1, 32'hFEEDFACE);
    tick();
    wb_valid_i = 0;
    #1;
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL ooo_blocked got=%0h exp=0", commit_valid_o); end
    set_wb(0, 4'd0, 32'h11);
    tick();
    wb_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (commit_valid_o !== 1'b1 || commit_result_o !== exp_res[k] || commit_pc_o !== 32'(k * 4)) begin bad++; $display("FAIL ooo_commit%0d got=%0h/%h/%h exp=1/%h/%h", k, commit_valid_o, commit_result_o, commit_pc_o, exp_res[k], 32'(k * 4)); end
      tick();
    end
    total++; if (rob_empty_o !== 1'b1) begin bad++; $display("FAIL ooo_empty got=%0h exp=1", rob_empty_o); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(32'(i * 4), 5'd3, 1'b1);
      tick();
    end
    clr_in();
    for (int j = 0; j < 8; j++) begin
      set_wb(0, 4'(2 * j), 32'(100 + 2 * j));
      set_wb(1, 4'(2 * j + 1), 32'(101 + 2 * j));
      tick();
    end
    clr_in();
    #1;
    total++; if (rob_full_o !== 1'b1 || alloc_ready_o !== 1'b0) begin bad++; $display("FAIL full_flags got=%0h/%0h exp=1/0", rob_full_o, alloc_ready_o); end
    set_alloc(32'h999, 5'd4, 1'b1);
    commit_ready_i = 1;
    #1;
    total++; if (commit_valid_o !== 1'b1 || commit_result_o !== 32'd100) begin bad++; $display("FAIL full_head got=%0h/%0d exp=1/100", commit_valid_o, commit_result_o); end
    tick();
    total++; if (alloc_ready_o !== 1'b1 || alloc_idx_o !== 4'd0 || rob_full_o !== 1'b0) begin bad++; $display("FAIL full_refused got=%0h/%0d/%0h exp=1/0/0", alloc_ready_o, alloc_idx_o, rob_full_o); end
    for (int k = 0; k < 20; k++) begin
      wb_valid_i = 0;
      if (k > 0) set_wb(0, 4'((k - 1) % 16), 32'(200 + k));
      #1;
      total++; if (alloc_idx_o !== 4'(k % 16) || commit_valid_o !== 1'b1) begin bad++; $display("FAIL wrap_step%0d got=%0d/%0h exp=%0d/1", k, alloc_idx_o, commit_valid_o, k % 16); end
      tick();
    end
    clr_in();
    #1;
    total++; if (alloc_idx_o !== 4'd4 || rob_full_o !== 1'b0 || rob_empty_o !== 1'b0) begin bad++; $display("FAIL wrap_end got=%0d/%0h/%0h exp=4/0/0", alloc_idx_o, rob_full_o, rob_empty_o); end
  endtask

  task automatic test_hazard();
    logic [4:0] rds [6];
    rds = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd4, 5'd7};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(32'(i * 4), rds[i], 1'b1);
      tick();
    end
    clr_in();
    rs1_addr_i = 5'd7; rs2_addr_i = 5'd0;
    #1;
    total++; if (hazard_rs1_o !== 1'b1 || rob_entry_rs1_o !== 4'd5 || completed_rs1_o !== 1'b0) begin bad++; $display("FAIL haz_youngest got=%0h/%0d/%0h exp=1/5/0", hazard_rs1_o, rob_entry_rs1_o, completed_rs1_o); end
    total++; if (hazard_rs2_o !== 1'b0) begin bad++; $display("FAIL haz_x0 got=%0h exp=0", hazard_rs2_o); end
    set_wb(1, 4'd5, 32'h1234);
    #1;
    total++; if (completed_rs1_o !== 1'b1 || result_rs1_o !== 32'h1234) begin bad++; $display("FAIL haz_bypass got=%0h/%h exp=1/00001234", completed_rs1_o, result_rs1_o); end
    rs2_addr_i = 5'd3;
    #1;
    total++; if (hazard_rs2_o !== 1'b1 || rob_entry_rs2_o !== 4'd2 || completed_rs2_o !== 1'b0) begin bad++; $display("FAIL haz_rs2 got=%0h/%0d/%0h exp=1/2/0", hazard_rs2_o, rob_entry_rs2_o, completed_rs2_o); end
    tick();
    wb_valid_i = 0;
    #1;
    total++; if (completed_rs1_o !== 1'b1 || result_rs1_o !== 32'h1234) begin bad++; $display("FAIL haz_stored got=%0h/%h exp=1/00001234", completed_rs1_o, result_rs1_o); end
  endtask

  task automatic test_same_idx();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(32'(i * 4), 5'(i + 1), 1'b1);
      tick();
    end
    clr_in();
    set_wb(0, 4'd0, 32'h1); set_wb(1, 4'd1, 32'h2);
    tick();
    set_wb(0, 4'd2, 32'h3); set_wb(1, 4'd3, 32'h4);
    tick();
    set_wb(0, 4'd4, 32'hAAAA); set_wb(1, 4'd4, 32'hBBBB);
    tick();
    clr_in();
    commit_ready_i = 1;
    repeat (4) tick();
    commit_ready_i = 0;
    #1;
    total++; if (commit_valid_o !== 1'b1 || commit_result_o !== 32'hBBBB) begin bad++; $display("FAIL same_idx got=%0h/%h exp=1/0000bbbb", commit_valid_o, commit_result_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (commit_valid_o !== 1'b1 || commit_result_o !== 32'hBBBB || commit_pc_o !== 32'h10) begin bad++; $display("FAIL hold%0d got=%0h/%h/%h exp=1/0000bbbb/00000010", c, commit_valid_o, commit_result_o, commit_pc_o); end
    end
    commit_ready_i = 1;
    tick();
    total++; if (rob_empty_o !== 1'b1) begin bad++; $display("FAIL same_drain got=%0h exp=1", rob_empty_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(32'(i * 4), 5'(i + 1), 1'b1);
      tick();
    end
    clr_in();
    set_wb(0, 4'd0, 32'h55);
    tick();
    clr_in();
    flush_i = 1;
    set_alloc(32'h80, 5'd9, 1'b1);
    set_wb(1, 4'd1, 32'h66);
    rs1_addr_i = 5'd2;
    commit_ready_i = 1;
    #1;
    total++; if (commit_valid_o !== 1'b0 || alloc_ready_o !== 1'b1) begin bad++; $display("FAIL flush_cycle got=%0h/%0h exp=0/1", commit_valid_o, alloc_ready_o); end
    tick();
    clr_in();
    rs1_addr_i = 5'd2; rs2_addr_i = 5'd9;
    #1;
    total++; if (rob_empty_o !== 1'b1 || alloc_idx_o !== 4'd0 || commit_valid_o !== 1'b0) begin bad++; $display("FAIL flush_state got=%0h/%0d/%0h exp=1/0/0", rob_empty_o, alloc_idx_o, commit_valid_o); end
    total++; if ({hazard_rs1_o, hazard_rs2_o} !== 2'b00) begin bad++; $display("FAIL flush_hazard got=%0b exp=00", {hazard_rs1_o, hazard_rs2_o}); end
    for (int i = 0; i < 3; i++) begin
      set_alloc(32'(i * 4), 5'd2, 1'b1);
      tick();
    end
    alloc_valid_i = 0;
    rstn_i = 0;
    tick();
    rstn_i = 1;
    #1;
    total++; if (rob_empty_o !== 1'b1 || alloc_idx_o !== 4'd0 || commit_valid_o !== 1'b0 || hazard_rs1_o !== 1'b0) begin bad++; $display("FAIL midreset got=%0h/%0d/%0h/%0h exp=1/0/0/0", rob_empty_o, alloc_idx_o, commit_valid_o, hazard_rs1_o); end
  endtask

  initial begin
    rstn_i = 0;
    clr_in();
    test_reset();
    test_basic();
    test_ooo();
    test_full_wrap();
    test_hazard();
    test_same_idx();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_mp.md
Name: rob_mp

Overview:
- Parametrised reorder buffer for the tartaruga core: circular queue allocated in order at decode, completed out of order by NUM_WB write-back ports, retired in order one entry per cycle.
- Sits between decode/issue and commit.
- Adds configurable depth, multiple write-back channels, a commit ready/valid handshake and same-cycle write-back bypass on the rs1/rs2 hazard lookups.

Parameters:
- DEPTH, 16, number of entries; power of two, ≥2.
- NUM_WB, 2, number of write-back ports.
- IDX_W, $clog2(DEPTH), entry index width (derived; not overridden).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; synchronous, active-low.
- flush_i  in  1  discard all entries.
- alloc_valid_i  in  1  decode requests an entry.
- alloc_ready_o  out  1  an entry is free (!full).
- pc_i  in  32  instruction PC.
- instr_i  in  32  instruction word.
- rd_addr_i  in  5  destination register.
- write_enable_i  in  1  instruction writes rd.
- store_to_mem_i  in  1  instruction is a store.
- alloc_idx_o  out  IDX_W  index given to this allocation (current tail).
- wb_valid_i  in  NUM_WB  per-port write-back strobe.
- wb_idx_i  in  NUM_WB*IDX_W  per-port target entry.
- wb_result_i  in  NUM_WB*32  per-port result.
- wb_new_pc_i  in  NUM_WB*32  per-port next PC.
- wb_branch_taken_i  in  NUM_WB  per-port branch-taken flag.
- commit_valid_o  out  1  head entry is complete.
- commit_ready_i  in  1  commit stage accepts the head.
- commit_pc_o, commit_instr_o, commit_result_o, commit_new_pc_o  out  32 each  head payload.
- commit_rd_addr_o  out  5  head rd.
- commit_write_enable_o, commit_store_to_mem_o, commit_branch_taken_o  out  1 each  head flags.
- rob_full_o  out  1  count == DEPTH.
- rob_empty_o  out  1  count == 0.
- rs1_addr_i, rs2_addr_i  in  5 each  source registers to check.
- hazard_rs1_o, hazard_rs2_o  out  1 each  a pending producer exists.
- rob_entry_rs1_o, rob_entry_rs2_o  out  IDX_W each  index of that producer.
- completed_rs1_o, completed_rs2_o  out  1 each  the producer's result is available.
- result_rs1_o, result_rs2_o  out  32 each  the producer's result.

Behaviour:
- State:
  - head and tail pointers, IDX_W bits, wrapping modulo DEPTH.
  - count, IDX_W+1 bits.
  - Per entry: valid, completed and payload.
- Reset (rstn_i low at a posedge):
  - head = tail = count = 0; all entries invalid.
  - Outputs after reset: alloc_ready_o=1, rob_empty_o=1, rob_full_o=0, commit_valid_o=0, all hazard_*=0, alloc_idx_o=0.
- Allocation:
  - Fires when alloc_valid_i & alloc_ready_o.
  - At the edge: entry[tail] is written with valid=1, completed=0 and the decode fields; tail advances by 1.
  - alloc_idx_o is combinational from tail.
  - When full, the allocation is refused even if a commit fires in the same cycle.
- Write-back:
  - Each port p with wb_valid_i[p] sets entry[wb_idx_i[p]].completed=1 and stores result, new_pc and branch_taken at the edge.
  - A write-back to an invalid entry is ignored.
  - Two ports targeting the same index in one cycle: the highest-numbered port wins.
  - Write-back to an entry allocated in the same cycle is ignored.
- Commit:
  - commit_valid_o = entry[head].valid & completed & !flush_i.
  - All commit payload outputs are combinational from entry[head] and forced to 0 when commit_valid_o=0.
  - Commit fires on commit_valid_o & commit_ready_i: entry[head] is invalidated and head advances. Commit latency from write-back is 1 cycle.
  - commit_ready_i low holds the head; payload stays stable.
- Count: count updates by +alloc −commit. A simultaneous alloc and commit leaves count unchanged.
- Flush:
  - flush_i has priority over allocation, write-back and commit in the same cycle.
  - Next cycle: head = tail = count = 0 and all entries invalid.
  - alloc_ready_o remains driven by count during the flush cycle, but no allocation is recorded.
- Hazard lookup (combinational, per source):
  - Candidate entries: valid, write_enable set, and rd == rs.
  - rs == 0 never produces a hazard.
  - The youngest candidate wins (nearest to tail, age = (idx − head) mod DEPTH).
  - completed_rsX_o / result_rsX_o come from the stored state, OR-bypassed by a same-cycle write-back to the winning index (highest port wins).
  - An allocation in the same cycle is not visible to the lookup.
- Wrap-around: indices DEPTH−1 → 0 for both pointers; the age computation must remain correct across the wrap.

Decomposition:
- tartaruga_pkg gains:
  - rob_mp_entry_t, a packed struct: valid, completed, pc, instr, rd, we, store, result, new_pc, branch_taken.
  - Default constants ROB_DEPTH=16 and ROB_NUM_WB=2.
- One sub-module, rob_mp_lookup: a youngest-match priority search plus bypass, instantiated once for rs1 and once for rs2.

Test Plan:
1. Reset, allocate PC 0x4 (rd=1, we=1), then write-back on port 0 with idx 0 and 0xDEADBEEF, commit_ready_i=1 → alloc_idx_o=0; commit_valid_o=1 the cycle after write-back with commit_result_o=0xDEADBEEF; rob_empty_o=1 after that.
2. Allocate 3 entries, write back idx 2 (0xCAFEBABE) then idx 1 (0xFEEDFACE) while idx 0 is still pending → no commit; after idx 0 completes, three commits on consecutive cycles in order 0,1,2.
3. Fill all 16 entries → rob_full_o=1, alloc_ready_o=0; a 17th alloc_valid_i is refused even while a commit fires; after 20 alloc/commit pairs the pointers wrap and alloc_idx_o sequences 15→0.
4. Entries 3 and 5 both write rd=7, rs1=7 → rob_entry_rs1_o=5; a same-cycle port-1 write-back to 5 of 0x1234 → completed_rs1_o=1 and result_rs1_o=0x1234; rs2=0 → hazard_rs2_o=0.
5. Both ports write back idx 4 in one cycle (0xAAAA on port 0, 0xBBBB on port 1) → the committed result is 0xBBBB; holding commit_ready_i=0 for 3 cycles keeps the payload stable.
6. flush_i with 6 entries present and an alloc and write-back in the same cycle → next cycle rob_empty_o=1, alloc_idx_o=0, commit_valid_o=0, no hazards; a mid-fill reset gives the same result.
